i2s_tx_param: RTL and testbench

- Parametrised I2S/left-justified stereo serializer; successor to the fixed 16-bit transmitter.
- Configurable sample width, slot width and bit-clock divider. Runtime format select.
- Valid/ready sample input with a one-entry holding register, plus underrun detection.
- Sits between the core audio mixer and the HDMI/analog audio DAC pins, in the clk_sys domain.

---
 rtl/i2s_tx_param.sv | 175 +++++++++++++++++
 tb/tb_i2s_tx_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_param.sv
// Parametrised I2S / left-justified stereo serializer with a one-entry sample holding register.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module i2s_tx_param #(
  parameter int AUDIO_DW = 16,
  parameter int SLOT_DW  = 16,
  parameter int DIV      = 24
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                fmt,
  input  logic                signed_sample,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AUDIO_DW-1:0] left_chan,
  input  logic [AUDIO_DW-1:0] right_chan,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(2 * SLOT_DW);
  localparam int PAD   = SLOT_DW - AUDIO_DW;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * SLOT_DW - 1);
  localparam logic [IDX_W-1:0] SLOT_N   = IDX_W'(SLOT_DW);

  // Offset-binary samples get their MSB flipped; the sample is left-aligned in the slot.
  function automatic logic [SLOT_DW-1:0] to_slot(input logic [AUDIO_DW-1:0] s, input logic sgn);
    logic [AUDIO_DW-1:0] v;
    v = s;
    v[AUDIO_DW-1] = s[AUDIO_DW-1] ^ ~sgn;
    return SLOT_DW'(v) << PAD;
  endfunction

  logic [DIV_W-1:0]    div_cnt_r;
  logic [IDX_W-1:0]    bit_idx_r;
  logic                sclk_r, lrclk_r, sdata_r, underrun_r, fmt_r, prev_bit_r;
  logic [SLOT_DW-1:0]  left_sr_r, right_sr_r;
  logic                hold_full_r, in_ready_r;
  logic [AUDIO_DW-1:0] hold_left_r, hold_right_r;

  logic                bit_en_s, fall_s, frame_start_s, right_slot_s, accept_s;
  logic                fmt_s, out_bit_s, sdata_nxt_s;
  logic [SLOT_DW-1:0]  load_left_s, load_right_s, cur_sr_s;

  assign bit_en_s      = (div_cnt_r == DIV_LAST);
  assign fall_s        = bit_en_s & sclk_r;
  assign frame_start_s = fall_s & (bit_idx_r == {IDX_W{1'b0}});
  assign right_slot_s  = (bit_idx_r >= SLOT_N);
  assign accept_s      = in_valid & in_ready_r;

  // Next serial bit: LJ sends the current shift MSB, I2S sends the bit delayed by one sclk.
  always_comb begin
    fmt_s        = fmt_r;
    load_left_s  = {SLOT_DW{1'b0}};
    load_right_s = {SLOT_DW{1'b0}};
    cur_sr_s     = left_sr_r;
    if (frame_start_s) begin
      fmt_s = fmt;
    end else begin
      fmt_s = fmt_r;
    end
    if (hold_full_r) begin
      load_left_s  = to_slot(hold_left_r, signed_sample);
      load_right_s = to_slot(hold_right_r, signed_sample);
    end else begin
      load_left_s  = {SLOT_DW{1'b0}};
      load_right_s = {SLOT_DW{1'b0}};
    end
    if (right_slot_s) begin
      cur_sr_s = right_sr_r;
    end else if (frame_start_s) begin
      cur_sr_s = load_left_s;
    end else begin
      cur_sr_s = left_sr_r;
    end
    out_bit_s = cur_sr_s[SLOT_DW-1];
    if (fmt_s) begin
      sdata_nxt_s = out_bit_s;
    end else begin
      sdata_nxt_s = prev_bit_r;
    end
  end

  // Bit-clock divider and sclk generation.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b1;
    end else begin
      div_cnt_r <= bit_en_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
      sclk_r    <= bit_en_s ? ~sclk_r : sclk_r;
    end
  end

  // Frame sequencing, shift registers and serial outputs, all updated on the sclk falling edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx_r  <= {IDX_W{1'b0}};
      lrclk_r    <= 1'b1;
      sdata_r    <= 1'b0;
      prev_bit_r <= 1'b0;
      fmt_r      <= 1'b0;
      underrun_r <= 1'b0;
      left_sr_r  <= {SLOT_DW{1'b0}};
      right_sr_r <= {SLOT_DW{1'b0}};
    end else begin
      underrun_r <= frame_start_s & ~hold_full_r;
      if (fall_s) begin
        bit_idx_r  <= (bit_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : bit_idx_r + IDX_W'(1);
        lrclk_r    <= right_slot_s;
        sdata_r    <= sdata_nxt_s;
        prev_bit_r <= out_bit_s;
        if (frame_start_s) begin
          fmt_r      <= fmt;
          left_sr_r  <= load_left_s << 1;
          right_sr_r <= load_right_s;
        end else if (right_slot_s) begin
          right_sr_r <= right_sr_r << 1;
        end else begin
          left_sr_r  <= left_sr_r << 1;
        end
      end
    end
  end

  // Holding register; an accept can only occur while empty, so a same-cycle load sees it empty.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_r  <= 1'b0;
      in_ready_r   <= 1'b1;
      hold_left_r  <= {AUDIO_DW{1'b0}};
      hold_right_r <= {AUDIO_DW{1'b0}};
    end else begin
      if (accept_s) begin
        hold_full_r  <= 1'b1;
        hold_left_r  <= left_chan;
        hold_right_r <= right_chan;
      end else if (frame_start_s) begin
        hold_full_r  <= 1'b0;
      end
      in_ready_r <= ~(accept_s | (hold_full_r & ~frame_start_s));
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_r;

  // Saturating count of frames started without a held sample.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt_r <= 16'h0000;
    end else if (frame_start_s && !hold_full_r && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'h0001;
    end else begin
      underrun_cnt_r <= underrun_cnt_r;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`endif

  assign in_ready = in_ready_r;
  assign sclk     = sclk_r;
  assign lrclk    = lrclk_r;
  assign sdata    = sdata_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_i2s_tx_param.sv
// Scoreboard bench for i2s_tx_param: two instances (16-bit and 24-bit slots), DIV = 2.
module tb_i2s_tx_param;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        fmt = 1'b0;
  logic        signed_sample = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] left_chan = 16'h0000;
  logic [15:0] right_chan = 16'h0000;
  logic        in_ready_a, sclk_a, lrclk_a, sdata_a, underrun_a;
  logic        in_ready_b, sclk_b, lrclk_b, sdata_b, underrun_b;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  logic sel = 1'b0;
  logic in_ready_m, sclk_m, lrclk_m, sdata_m, underrun_m;
  assign in_ready_m = sel ? in_ready_b : in_ready_a;
  assign sclk_m     = sel ? sclk_b     : sclk_a;
  assign lrclk_m    = sel ? lrclk_b    : lrclk_a;
  assign sdata_m    = sel ? sdata_b    : sdata_a;
  assign underrun_m = sel ? underrun_b : underrun_a;

  typedef struct packed {logic lr; logic sd; logic ur;} exp_t;
  exp_t exp_q[$];
  logic carry_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_sys = ~clk_sys;

  i2s_tx_param #(.AUDIO_DW(16), .SLOT_DW(16), .DIV(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .fmt(fmt), .signed_sample(signed_sample),
    .in_valid(in_valid), .in_ready(in_ready_a), .left_chan(left_chan), .right_chan(right_chan),
    .sclk(sclk_a), .lrclk(lrclk_a), .sdata(sdata_a), .underrun(underrun_a)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt_a)
`endif
  );

  i2s_tx_param #(.AUDIO_DW(16), .SLOT_DW(24), .DIV(2)) dut24 (
    .clk_sys(clk_sys), .reset_n(reset_n), .fmt(fmt), .signed_sample(signed_sample),
    .in_valid(in_valid), .in_ready(in_ready_b), .left_chan(left_chan), .right_chan(right_chan),
    .sclk(sclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .underrun(underrun_b)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt_b)
`endif
  );

  // Expected {lrclk, sdata, underrun} for every falling edge of one frame.
  task automatic push_frame(input logic f, input logic [15:0] l, input logic [15:0] r,
                            input logic ur, input int slot);
    exp_t        e;
    logic [15:0] w;
    logic        b;
    for (int ch = 0; ch < 2; ch++) begin
      w = (ch == 0) ? l : r;
      for (int p = 0; p < slot; p++) begin
        b = 1'b0;
        if (f) begin
          if (p < 16) b = w[15-p];
        end else if (p == 0) begin
          b = (ch == 0) ? carry_b : ((slot == 16) ? l[0] : 1'b0);
        end else if (p <= 16) begin
          b = w[16-p];
        end
        e.lr = (ch == 1);
        e.sd = b;
        e.ur = (ch == 0 && p == 0) ? ur : 1'b0;
        exp_q.push_back(e);
      end
    end
    carry_b = (slot == 16) ? r[0] : 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    logic prev;
    prev = sclk_m;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (prev && !sclk_m) begin
        ok = 1'b1;
        break;
      end
      prev = sclk_m;
    end
  endtask

  task automatic run_n(input string name, input int n);
    bit   ok;
    exp_t e, obs;
    for (int i = 0; i < n; i++) begin
      wait_fall(ok);
      if (!ok) begin
        errors++;
        $display("FAIL %s sclk_timeout at fall %0d", name, i);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      obs = {lrclk_m, sdata_m, underrun_m};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s fall %0d: got lr/sd/ur=%b required %b", name, i, obs, e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    in_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.delete();
    carry_b = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
    int n;
    in_valid = 1'b1;
    left_chan = l;
    right_chan = r;
    n = 0;
    while (!in_ready_m && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (!in_ready_m) begin
      errors++;
      $display("FAIL push_timeout: in_ready got %b required 1", in_ready_m);
    end
    @(negedge clk_sys);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int   n;
    logic prev;
    sel = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (sclk_m !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b required 1", sclk_m); end
    if (lrclk_m !== 1'b1) begin errors++; $display("FAIL reset_lrclk: got %b required 1", lrclk_m); end
    if (sdata_m !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b required 0", sdata_m); end
    if (underrun_m !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun_m); end
    if (in_ready_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready_m); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      prev = sclk_m;
      n = 0;
      while (sclk_m === prev && n < 50) begin
        @(negedge clk_sys);
        n++;
      end
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL sclk_half_period %0d: got %0d cycles required 2", k, n);
      end
    end
  endtask

  task automatic test_idle();
    sel = 1'b0;
    do_reset();
    fmt = 1'b0;
    push_frame(1'b0, 16'h0000, 16'h0000, 1'b1, 16);
    push_frame(1'b0, 16'h0000, 16'h0000, 1'b1, 16);
    run_n("idle", exp_q.size());
  endtask

  task automatic test_format(input string name, input logic f, input logic sgn,
                             input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] l_tx, input logic [15:0] r_tx);
    sel = 1'b0;
    do_reset();
    fmt = f;
    signed_sample = sgn;
    push_sample(l, r);
    push_frame(f, l_tx, r_tx, 1'b0, 16);
    push_frame(f, 16'h0000, 16'h0000, 1'b1, 16);
    run_n(name, exp_q.size());
    signed_sample = 1'b1;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_reset();
    fmt = 1'b0;
    push_sample(16'hA5C3, 16'h3C5A);
    push_frame(1'b0, 16'hA5C3, 16'h3C5A, 1'b0, 16);
    run_n("b2b_head", 3);
    push_sample(16'h1234, 16'hFEDC);
    checks++;
    if (in_ready_m !== 1'b0) begin
      errors++;
      $display("FAIL b2b_in_ready: got %b required 0", in_ready_m);
    end
    push_frame(1'b0, 16'h1234, 16'hFEDC, 1'b0, 16);
    push_frame(1'b0, 16'h0000, 16'h0000, 1'b1, 16);
    run_n("b2b", exp_q.size());
  endtask

  task automatic test_slot24();
    sel = 1'b1;
    do_reset();
    fmt = 1'b1;
    push_sample(16'hFFFF, 16'h8421);
    push_frame(1'b1, 16'hFFFF, 16'h8421, 1'b0, 24);
    push_frame(1'b1, 16'h0000, 16'h0000, 1'b1, 24);
    run_n("slot24", exp_q.size());
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    fmt = 1'b0;
    push_sample(16'h8001, 16'h7FFE);
    push_frame(1'b0, 16'h8001, 16'h7FFE, 1'b0, 16);
    run_n("mid_pre", 21);
    push_sample(16'h1111, 16'h2222);
    checks++;
    if (in_ready_m !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: in_ready got %b required 0", in_ready_m);
    end
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (sclk_m !== 1'b1) begin errors++; $display("FAIL mid_sclk: got %b required 1", sclk_m); end
    if (lrclk_m !== 1'b1) begin errors++; $display("FAIL mid_lrclk: got %b required 1", lrclk_m); end
    if (sdata_m !== 1'b0) begin errors++; $display("FAIL mid_sdata: got %b required 0", sdata_m); end
    if (in_ready_m !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", in_ready_m); end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.delete();
    carry_b = 1'b0;
    push_frame(1'b0, 16'h0000, 16'h0000, 1'b1, 16);
    run_n("mid_post", exp_q.size());
  endtask

  initial begin
    test_reset();
    test_idle();
    test_format("i2s", 1'b0, 1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE);
    test_format("lj", 1'b1, 1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE);
    test_format("unsigned", 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF);
    test_back_to_back();
    test_slot24();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
